// File: rtl/apb3_timer_pkg.sv
// rtl/apb3_timer_pkg.sv - register offsets, CTRL layout and decode helper for apb3_timer
package apb3_timer_pkg;

  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PRESC  = 8'h04;
  localparam logic [7:0] TMR_CMP    = 8'h08;
  localparam logic [7:0] TMR_COUNT  = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  // Misaligned offsets never match a register, so this also covers alignment errors.
  function automatic logic is_mapped(input logic [7:0] off);
    return (off == TMR_CTRL) || (off == TMR_PRESC) || (off == TMR_CMP) ||
           (off == TMR_COUNT) || (off == TMR_STATUS);
  endfunction

endpackage

// File: rtl/apb3_timer_prescaler.sv
// rtl/apb3_timer_prescaler.sv - divide-by-(presc+1) tick generator for apb3_timer
module apb3_timer_prescaler
  import apb3_timer_pkg::*;
#(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic                   o_tick
);

  logic [PRESC_WIDTH-1:0] pcnt;

  assign o_tick = i_en & (pcnt == i_presc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pcnt <= '0;
    end else if (!i_en || i_clr || o_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb3_timer.sv
// rtl/apb3_timer.sv - APB3 prescaled compare timer with maskable level interrupt
module apb3_timer
  import apb3_timer_pkg::*;
#(
  parameter int APB3_ADDR_WIDTH = 32,
  parameter int APB3_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 32,
  parameter int PRESC_WIDTH     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_psel,
  input  logic                       i_penable,
  input  logic                       i_pwrite,
  input  logic [APB3_ADDR_WIDTH-1:0] i_paddr,
  input  logic [APB3_DATA_WIDTH-1:0] i_pwdata,
  output logic [APB3_DATA_WIDTH-1:0] o_prdata,
  output logic                       o_pready,
  output logic                       o_pslverr,
  output logic                       o_irq
);

  logic [7:0]             offset;
  logic                   addr_err;
  logic                   setup_phase;
  logic                   wr_en;
  logic                   wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  ctrl_t                  ctrl;
  logic [PRESC_WIDTH-1:0] presc;
  logic [CNT_WIDTH-1:0]   cmp;
  logic [CNT_WIDTH-1:0]   count;
  logic                   pend;
  logic                   tick;
  logic                   match;
  logic                   presc_clr;
  logic [APB3_DATA_WIDTH-1:0] rdata;
  logic                   unused_paddr;

  assign offset       = i_paddr[7:0];
  assign unused_paddr = ^i_paddr[APB3_ADDR_WIDTH-1:8];
  assign addr_err     = !is_mapped(offset);
  assign setup_phase  = i_psel & ~i_penable;
  assign wr_en        = i_psel & i_penable & i_pwrite & ~addr_err;
  assign wr_ctrl      = wr_en & (offset == TMR_CTRL);
  assign wr_presc     = wr_en & (offset == TMR_PRESC);
  assign wr_cmp       = wr_en & (offset == TMR_CMP);
  assign wr_count     = wr_en & (offset == TMR_COUNT);
  assign wr_status    = wr_en & (offset == TMR_STATUS);
  assign o_pready     = 1'b1;

  // Restart the prescale period on PRESC writes and on enabling from idle.
  assign presc_clr = wr_presc | (wr_ctrl & i_pwdata[CTRL_EN] & ~ctrl.en);
  assign match     = tick & (count == cmp);

  apb3_timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (ctrl.en),
    .i_clr  (presc_clr),
    .i_presc(presc),
    .o_tick (tick)
  );

  always_comb begin
    rdata = '0;
    case (offset)
      TMR_CTRL:   rdata[2:0]             = ctrl;
      TMR_PRESC:  rdata[PRESC_WIDTH-1:0] = presc;
      TMR_CMP:    rdata[CNT_WIDTH-1:0]   = cmp;
      TMR_COUNT:  rdata[CNT_WIDTH-1:0]   = count;
      TMR_STATUS: rdata[0]               = pend;
      default:    rdata                  = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_prdata  <= '0;
      o_pslverr <= 1'b0;
    end else if (setup_phase) begin
      o_prdata  <= (i_pwrite || addr_err) ? '0 : rdata;
      o_pslverr <= addr_err;
    end
  end

  // A software CTRL write takes priority over the one-shot auto-disable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.en       <= i_pwdata[CTRL_EN];
      ctrl.periodic <= i_pwdata[CTRL_PERIODIC];
      ctrl.irq_en   <= i_pwdata[CTRL_IRQ_EN];
    end else if (match && !ctrl.periodic) begin
      ctrl.en <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc <= '0;
      cmp   <= '0;
    end else begin
      if (wr_presc) presc <= i_pwdata[PRESC_WIDTH-1:0];
      if (wr_cmp)   cmp   <= i_pwdata[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= i_pwdata[CNT_WIDTH-1:0];
    end else if (match) begin
      if (ctrl.periodic) count <= '0;
    end else if (tick) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // A match in the same cycle as a W1C keeps PEND set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend  <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      if (match) begin
        pend <= 1'b1;
      end else if (wr_status && i_pwdata[0]) begin
        pend <= 1'b0;
      end
      o_irq <= pend & ctrl.irq_en;
    end
  end

endmodule

// File: tb/tb_apb3_timer.sv
// tb/tb_apb3_timer.sv - scoreboard bench for apb3_timer against a cycle-level reference model
module tb_apb3_timer;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb3_timer dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_psel   (psel),
    .i_penable(penable),
    .i_pwrite (pwrite),
    .i_paddr  (paddr),
    .i_pwdata (pwdata),
    .o_prdata (prdata),
    .o_pready (pready),
    .o_pslverr(pslverr),
    .o_irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {pslverr, prdata} per transfer, pushed when the setup phase is issued.
  logic [32:0] exp_q[$];

  logic        m_en, m_per, m_irqen, m_pend, m_irq;
  logic [15:0] m_presc;
  logic [31:0] m_cmp, m_count;
  int unsigned m_pcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:   return {29'd0, m_irqen, m_per, m_en};
      8'h04:   return {16'd0, m_presc};
      8'h08:   return m_cmp;
      8'h0C:   return m_count;
      8'h10:   return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: one step per clock, following the timer's documented rules.
  initial begin
    logic [7:0] off;
    bit err, wr, tick, hit, en_rise;
    m_en = 0; m_per = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
    m_presc = 0; m_cmp = 0; m_count = 0; m_pcnt = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_en = 0; m_per = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
        m_presc = 0; m_cmp = 0; m_count = 0; m_pcnt = 0;
        exp_q.delete();
      end else begin
        off  = paddr[7:0];
        err  = !(off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10});
        if (psel && !penable)
          exp_q.push_back({err, (pwrite || err) ? 32'd0 : model_read(off)});
        wr   = psel && penable && pwrite && !err;
        tick = m_en && (m_pcnt == m_presc);
        hit  = tick && (m_count == m_cmp);
        en_rise = wr && off == 8'h00 && pwdata[0] && !m_en;
        m_irq = m_pend && m_irqen;
        m_pcnt = (!m_en || tick || en_rise || (wr && off == 8'h04)) ? 0 : m_pcnt + 1;
        if (wr && off == 8'h0C) m_count = pwdata;
        else if (hit)           m_count = m_per ? 32'd0 : m_count;
        else if (tick)          m_count = m_count + 32'd1;
        if (wr && off == 8'h00) {m_irqen, m_per, m_en} = pwdata[2:0];
        else if (hit && !m_per) m_en = 0;
        if (hit) m_pend = 1;
        else if (wr && off == 8'h10 && pwdata[0]) m_pend = 0;
        if (wr && off == 8'h04) m_presc = pwdata[15:0];
        if (wr && off == 8'h08) m_cmp = pwdata;
      end
    end
  end

  // Monitor: compares each completed transfer and the interrupt line every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      if (psel && penable && pready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("prdata", prdata, e[31:0]);
          chk("pslverr", {31'd0, pslverr}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0; pwdata = 0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr,
                          input logic [31:0] exp, input bit exp_err);
    apb(0, addr, 32'd0);
    chk(name, prdata, exp);
    chk({name, "_err"}, {31'd0, pslverr}, {31'd0, exp_err});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h00;
      1: return 32'h04;
      2: return 32'h08;
      3: return 32'h0C;
      4: return 32'h10;
      5: return 32'h14;
      6: return 32'h02;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_data(input logic [7:0] off);
    case (off)
      8'h04: return $urandom_range(0, 3);
      8'h08: return $urandom_range(0, 12);
      8'h0C: return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                : $urandom_range(0, 12);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    idle(3);
    rst = 0;

    // Reset state
    rd_check("rst_ctrl",   32'h00, 32'd0, 0);
    rd_check("rst_presc",  32'h04, 32'd0, 0);
    rd_check("rst_cmp",    32'h08, 32'd0, 0);
    rd_check("rst_count",  32'h0C, 32'd0, 0);
    rd_check("rst_status", 32'h10, 32'd0, 0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("pready", {31'd0, pready}, 32'd1);

    // Periodic: PRESC=3, CMP=4 -> PEND 20 clocks after enable
    apb(1, 32'h04, 32'd3);
    apb(1, 32'h08, 32'd4);
    apb(1, 32'h00, 32'h7);
    idle(20);
    chk("periodic_irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    chk("periodic_irq_after", {31'd0, irq}, 32'd1);
    idle(23);
    apb(1, 32'h00, 32'h0);
    apb(1, 32'h10, 32'h1);

    // One-shot: CMP=2, PRESC=0
    apb(1, 32'h0C, 32'd0);
    apb(1, 32'h04, 32'd0);
    apb(1, 32'h08, 32'd2);
    apb(1, 32'h00, 32'h5);
    idle(5);
    rd_check("oneshot_ctrl",  32'h00, 32'h4, 0);
    rd_check("oneshot_count", 32'h0C, 32'd2, 0);
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    apb(1, 32'h10, 32'h1);
    chk("w1c_irq_hold", {31'd0, irq}, 32'd1);
    idle(1);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);

    // Wrap: COUNT=FFFF_FFFE, CMP=1
    apb(1, 32'h08, 32'd1);
    apb(1, 32'h0C, 32'hFFFF_FFFE);
    apb(1, 32'h00, 32'h1);
    idle(2);
    rd_check("wrap_count0", 32'h0C, 32'd0, 0);
    rd_check("wrap_pend",   32'h10, 32'd1, 0);
    rd_check("wrap_ctrl",   32'h00, 32'd0, 0);
    rd_check("wrap_count1", 32'h0C, 32'd1, 0);

    // Unmapped and misaligned offsets
    apb(1, 32'h04, 32'd2);
    rd_check("unmapped_rd",   32'h14, 32'd0, 1);
    apb(1, 32'h14, 32'hFFFF_FFFF);
    apb(1, 32'h02, 32'hFFFF_FFFF);
    rd_check("misaligned_rd", 32'h02, 32'd0, 1);
    rd_check("err_presc",     32'h04, 32'd2, 0);
    rd_check("err_ctrl",      32'h00, 32'd0, 0);

    // W1C in the same clock as a match; COUNT write in the same clock as a tick
    apb(1, 32'h10, 32'h1);
    apb(1, 32'h0C, 32'd0);
    apb(1, 32'h04, 32'd0);
    apb(1, 32'h08, 32'd5);
    apb(1, 32'h00, 32'h3);
    idle(4);
    apb(1, 32'h10, 32'h1);
    rd_check("w1c_vs_match", 32'h10, 32'd1, 0);
    apb(1, 32'h0C, 32'h100);
    rd_check("count_wr_vs_tick", 32'h0C, 32'h100, 0);
    apb(1, 32'h00, 32'h0);

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      a = rand_addr();
      apb($urandom_range(0, 1) == 1, a, rand_data(a[7:0]));
      idle($urandom_range(0, 4));
    end

    // Reset in the middle of a pending interrupt
    apb(1, 32'h04, 32'd0);
    apb(1, 32'h08, 32'd1);
    apb(1, 32'h0C, 32'd0);
    apb(1, 32'h00, 32'h7);
    idle(4);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2 rst = 1;
    #1 chk("async_reset_irq", {31'd0, irq}, 32'd0);
    chk("async_reset_prdata", prdata, 32'd0);
    idle(2);
    rst = 0;
    rd_check("post_reset_ctrl",   32'h00, 32'd0, 0);
    rd_check("post_reset_status", 32'h10, 32'd0, 0);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
